// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the line reader/writer state encoding.
package fb_pkg;
  localparam int FB_FRAME_WIDTH  = 256;
  localparam int FB_FRAME_HEIGHT = 256;
  localparam int FB_ADDR_WIDTH   = 16;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} fb_state_t;
endpackage

// File: rtl/fb_sync_fifo.sv
// Parameterised synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
module fb_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/framebuffer_line_reader.sv
// Streams one framebuffer line from BRAM as valid/ready pixels with a last marker.
// Optional FB_READER_AUTO_ADVANCE_EN: free-running line advance and a frame_start output.
module framebuffer_line_reader
  import fb_pkg::*;
#(
  parameter int FRAME_WIDTH  = FB_FRAME_WIDTH,
  parameter int PIXEL_WIDTH  = 1,
  parameter int BRAM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               line_y,
  output logic                     busy,
  output logic [FB_ADDR_WIDTH-1:0] bram_addr,
  input  logic [PIXEL_WIDTH-1:0]   bram_data_out,
  output logic                     axiov,
  output logic [PIXEL_WIDTH-1:0]   axiod,
  output logic                     axiolast,
`ifdef FB_READER_AUTO_ADVANCE_EN
  output logic                     frame_start,
`endif
  input  logic                     axioready
);
  localparam int XSHIFT = $clog2(FRAME_WIDTH);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] X_LAST = 8'(FRAME_WIDTH - 1);

  if (FIFO_DEPTH < BRAM_LATENCY + 1) begin : g_bad_depth
    $error("FIFO_DEPTH too small to cover BRAM_LATENCY");
  end

  function automatic logic [FB_ADDR_WIDTH-1:0] line_base(input logic [7:0] y);
    return FB_ADDR_WIDTH'({8'd0, y}) << XSHIFT;
  endfunction

  fb_state_t              state;
  logic [7:0]             rd_x;
  logic [7:0]             out_x;
  logic [BRAM_LATENCY-1:0] tag;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            occupancy;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PIXEL_WIDTH-1:0] fifo_head;
  logic                   issue;
  logic                   transfer;
  logic                   last_xfer;
`ifdef FB_READER_AUTO_ADVANCE_EN
  logic [7:0]             cur_line;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) inflight = inflight + CW'(tag[i]);
  end

  // Reads still in flight count against FIFO space so pushes can never overflow.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue     = (state == READ) && (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign axiov     = !fifo_empty;
  assign axiod     = fifo_empty ? '0 : fifo_head;
  assign transfer  = axiov && axioready;
  assign axiolast  = axiov && (out_x == X_LAST);
  assign last_xfer = transfer && axiolast;
`ifdef FB_READER_AUTO_ADVANCE_EN
  assign frame_start = axiov && (out_x == 8'd0) && (cur_line == 8'd0);
`endif

  fb_sync_fifo #(.WIDTH(PIXEL_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag[BRAM_LATENCY-1]),
    .pop   (transfer),
    .din   (bram_data_out),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(tag[BRAM_LATENCY-1] && fifo_full && !transfer))
        else $error("prefetch fifo overflow");
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tag <= '0;
    else     tag <= (tag << 1) | BRAM_LATENCY'(issue);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rd_x      <= '0;
      out_x     <= '0;
      bram_addr <= '0;
`ifdef FB_READER_AUTO_ADVANCE_EN
      cur_line  <= '0;
`endif
    end else begin
      if (transfer) out_x <= last_xfer ? 8'd0 : out_x + 8'd1;
      case (state)
        IDLE: begin
          if (start) begin
            bram_addr <= line_base(line_y);
            rd_x      <= '0;
            out_x     <= '0;
            busy      <= 1'b1;
            state     <= READ;
`ifdef FB_READER_AUTO_ADVANCE_EN
            cur_line  <= line_y;
`endif
          end
        end
        READ: begin
          // bram_addr parks on the final address rather than stepping past it.
          if (issue) begin
            if (rd_x == X_LAST) begin
              state <= DRAIN;
            end else begin
              rd_x      <= rd_x + 8'd1;
              bram_addr <= bram_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (last_xfer) begin
`ifdef FB_READER_AUTO_ADVANCE_EN
            cur_line  <= cur_line + 8'd1;
            bram_addr <= line_base(cur_line + 8'd1);
            rd_x      <= '0;
            state     <= READ;
`else
            busy      <= 1'b0;
            state     <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
